// File: rtl/l3_bus_feeder.sv
// Two-requester round-robin front end feeding a small FIFO whose head is
// issued, one word per permitted cycle, onto the registered L3 cell-array bus.
module l3_bus_feeder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] IDLE_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        bus_en,
    output logic [31:0] bus_out,
    output logic        bus_valid,
    output logic [4:0]  fifo_count
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_CNT = 5'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          prio;
    logic          full;
    logic          empty;
    logic          grant0;
    logic          grant1;
    logic          push;
    logic          pop;
    logic [31:0]   push_data;

    // prio == 0 favours port 0 on contention; a lone requester always wins
    assign full       = (fifo_count == DEPTH_CNT);
    assign empty      = (fifo_count == 5'd0);
    assign grant0     = req0_valid && (!req1_valid || !prio);
    assign grant1     = req1_valid && (!req0_valid || prio);
    assign req0_ready = rst_n && !full && grant0;
    assign req1_ready = rst_n && !full && grant1;
    assign push       = req0_ready || req1_ready;
    assign push_data  = req1_ready ? req1_data : req0_data;
    assign pop        = bus_en && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pop decisions use registered occupancy, so a word pushed this edge can
    // never be the one popped at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= 5'd0;
            prio       <= 1'b0;
            bus_out    <= IDLE_WORD;
            bus_valid  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                prio   <= req0_ready;
            end
            if (pop) begin
                bus_out   <= mem[rd_ptr];
                bus_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end else begin
                bus_out   <= IDLE_WORD;
                bus_valid <= 1'b0;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_l3_bus_feeder.sv
// Bench for l3_bus_feeder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_l3_bus_feeder;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] IDLE_WORD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_data = '0;
    logic        req1_ready;
    logic        bus_en = 1'b0;
    logic [31:0] bus_out;
    logic        bus_valid;
    logic [4:0]  fifo_count;

    int checks = 0;
    int fails  = 0;

    logic [31:0] m_q[$];
    bit          m_prio = 1'b0;
    logic [31:0] m_bus_out = IDLE_WORD;
    bit          m_bus_valid = 1'b0;
    bit          m_r0;
    bit          m_r1;
    bit          m_pop;

    l3_bus_feeder #(.DEPTH(DEPTH), .IDLE_WORD(IDLE_WORD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .bus_en     (bus_en),
        .bus_out    (bus_out),
        .bus_valid  (bus_valid),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected handshake from the model's occupancy and pointer plus live inputs
    function automatic bit exp_ready(input int k);
        if (!rst_n || m_q.size() >= DEPTH) return 1'b0;
        if (k == 0) return req0_valid && (!req1_valid || !m_prio);
        return req1_valid && (!req0_valid || m_prio);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_prio      = 1'b0;
            m_bus_out   = IDLE_WORD;
            m_bus_valid = 1'b0;
        end else begin
            m_r0  = exp_ready(0);
            m_r1  = exp_ready(1);
            m_pop = bus_en && (m_q.size() > 0);
            if (m_pop) begin
                m_bus_out   = m_q.pop_front();
                m_bus_valid = 1'b1;
            end else begin
                m_bus_out   = IDLE_WORD;
                m_bus_valid = 1'b0;
            end
            if (m_r0) begin
                m_q.push_back(req0_data);
                m_prio = 1'b1;
            end else if (m_r1) begin
                m_q.push_back(req1_data);
                m_prio = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check_output("req0_ready", 32'(req0_ready), 32'(exp_ready(0)));
        check_output("req1_ready", 32'(req1_ready), 32'(exp_ready(1)));
        check_output("bus_valid", 32'(bus_valid), 32'(m_bus_valid));
        check_output("bus_out", bus_out, m_bus_out);
        check_output("fifo_count", 32'(fifo_count), m_q.size());
    end

    task automatic apply_stimulus(input bit v0, input logic [31:0] d0,
                                  input bit v1, input logic [31:0] d1, input bit en);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        bus_en     = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        bus_en     = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_order[4];
        logic [31:0] got[$];
        int          en_pct;

        #1 rst_n = 1'b0;
        req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_ready0", 32'(req0_ready), 32'd0);
        check_output("reset_count", 32'(fifo_count), 32'd0);
        check_output("reset_bus_out", bus_out, IDLE_WORD);
        rst_n = 1'b1;

        // Single push then drain, two-edge latency
        apply_stimulus(1, 32'h1234_5678, 0, 0, 1);
        check_output("single_count", 32'(fifo_count), 32'd1);
        check_output("single_not_yet", 32'(bus_valid), 32'd0);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("single_out", bus_out, 32'h1234_5678);
        check_output("single_valid", 32'(bus_valid), 32'd1);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("single_idle", bus_out, IDLE_WORD);
        check_output("single_idle_valid", 32'(bus_valid), 32'd0);

        // Contention fill then ordered drain
        do_reset();
        apply_stimulus(1, 32'hA0, 1, 32'hB0, 0);
        apply_stimulus(1, 32'hA1, 1, 32'hB0, 0);
        apply_stimulus(1, 32'hA1, 1, 32'hB1, 0);
        apply_stimulus(1, 32'hA2, 1, 32'hB1, 0);
        check_output("contend_count", 32'(fifo_count), 32'd4);
        check_output("contend_ready0", 32'(req0_ready), 32'd0);
        check_output("contend_ready1", 32'(req1_ready), 32'd0);
        exp_order = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 0, 0, 1);
            check_output("drain_word", bus_out, exp_order[i]);
            check_output("drain_count", 32'(fifo_count), 32'(3 - i));
        end

        // Full with simultaneous pop: push blocked, then accepted
        do_reset();
        for (int i = 0; i < 4; i++) apply_stimulus(1, 32'hC0 + i, 0, 0, 0);
        check_output("full_count", 32'(fifo_count), 32'd4);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 32'hD0;
        bus_en     = 1'b1;
        #1;
        check_output("full_ready1_low", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        check_output("full_pop_count", 32'(fifo_count), 32'd3);
        check_output("full_pop_word", bus_out, 32'hC0);
        check_output("full_ready1_high", 32'(req1_ready), 32'd1);
        bus_en = 1'b0;
        @(posedge clk);
        #1;
        check_output("full_refill_count", 32'(fifo_count), 32'd4);
        exp_order = '{32'hC1, 32'hC2, 32'hC3, 32'hD0};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 0, 0, 1);
            check_output("full_drain_word", bus_out, exp_order[i]);
        end

        // Wrap-around with occupancy held at two
        do_reset();
        got.delete();
        apply_stimulus(1, 32'hE0, 0, 0, 0);
        apply_stimulus(1, 32'hE1, 0, 0, 0);
        for (int i = 2; i < 10; i++) begin
            apply_stimulus(1, 32'hE0 + i, 0, 0, 1);
            if (bus_valid) got.push_back(bus_out);
            check_output("wrap_occupancy", 32'(fifo_count), 32'd2);
        end
        repeat (3) begin
            apply_stimulus(0, 0, 0, 0, 1);
            if (bus_valid) got.push_back(bus_out);
        end
        check_output("wrap_total", got.size(), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++)
            check_output("wrap_word", got[i], 32'hE0 + i);

        // Reset mid-stream discards contents
        do_reset();
        for (int i = 0; i < 3; i++) apply_stimulus(1, 32'hF0 + i, 0, 0, 0);
        check_output("midrst_pre_count", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check_output("midrst_valid", 32'(bus_valid), 32'd0);
        check_output("midrst_count", 32'(fifo_count), 32'd0);
        check_output("midrst_bus_out", bus_out, IDLE_WORD);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            apply_stimulus(0, 0, 0, 0, 1);
            check_output("midrst_no_stale", 32'(bus_valid), 32'd0);
        end

        // Randomized traffic with occasional reset pulses
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en_pct = ((i / 250) % 3 == 0) ? 20 : (((i / 250) % 3 == 1) ? 50 : 90);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                apply_stimulus($urandom_range(0, 3) != 0, $urandom(),
                               $urandom_range(0, 3) != 0, $urandom(),
                               $urandom_range(0, 99) < en_pct);
            end
        end
        apply_stimulus(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
